// File: rtl/fir_xifu_ctrl.sv
// fir_xifu_ctrl
// In-order issue/commit scoreboard and dispatch controller for the FIR XIF unit.
// Offloaded instructions (xfirlw / xfirsw / xfirdotp) are buffered in a small
// circular FIFO once accepted on the issue interface. They are released to EX
// in program order only after the core commits them. Killed entries are dropped
// silently. A per-register pending-write mask holds back the head entry while
// any FIR register it touches still has a write in flight in EX/WB.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), asynchronous active-low reset
//   issue_valid_i/ready_o      issue handshake
//   issue_instr_i, issue_id_i  instruction encoding and XIF ID
//   issue_rs1/rs2/rd_i         internal FIR register indices
//   commit_valid_i/id_i/kill_i commit (kill=0) or kill (kill=1) strobe for an ID
//   dispatch_valid_o/ready_i   head entry release to EX
//   dispatch_instr/id/rs1/rs2/rd_o  head entry fields (0 while the FIFO is empty)
//   wb_valid_i, wb_rd_i        WB write to the internal register file
//   busy_o                     any entry valid or any pending write outstanding
//
// Instruction encoding: 0 = INVALID, 1 = XFIRLW, 2 = XFIRSW, 3 = XFIRDOTP.
module fir_xifu_ctrl #(
  parameter int X_ID_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int NREGS      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [1:0]            issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [4:0]            issue_rs1_i,
  input  logic [4:0]            issue_rs2_i,
  input  logic [4:0]            issue_rd_i,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  dispatch_valid_o,
  input  logic                  dispatch_ready_i,
  output logic [1:0]            dispatch_instr_o,
  output logic [X_ID_WIDTH-1:0] dispatch_id_o,
  output logic [4:0]            dispatch_rs1_o,
  output logic [4:0]            dispatch_rs2_o,
  output logic [4:0]            dispatch_rd_o,
  input  logic                  wb_valid_i,
  input  logic [4:0]            wb_rd_i,
  output logic                  busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] INSTR_INVALID  = 2'd0;
  localparam logic [1:0] INSTR_XFIRLW   = 2'd1;
  localparam logic [1:0] INSTR_XFIRSW   = 2'd2;
  localparam logic [1:0] INSTR_XFIRDOTP = 2'd3;

  function automatic logic [NREGS-1:0] f_bit(input logic [4:0] idx);
    f_bit = {{(NREGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Every register an instruction reads or writes; any pending bit here blocks it.
  function automatic logic [NREGS-1:0] f_use(input logic [1:0] instr,
                                             input logic [4:0] rs1,
                                             input logic [4:0] rs2,
                                             input logic [4:0] rd);
    case (instr)
      INSTR_XFIRLW:   f_use = f_bit(rd);
      INSTR_XFIRSW:   f_use = f_bit(rs2);
      INSTR_XFIRDOTP: f_use = f_bit(rs1) | f_bit(rs2) | f_bit(rd);
      default:        f_use = '0;
    endcase
  endfunction

  function automatic logic f_writes(input logic [1:0] instr);
    f_writes = (instr == INSTR_XFIRLW) || (instr == INSTR_XFIRDOTP);
  endfunction

  // Entry payload (no reset needed: only read when the matching valid bit is set)
  logic [1:0]            r_instr [DEPTH];
  logic [X_ID_WIDTH-1:0] r_id    [DEPTH];
  logic [4:0]            r_rs1   [DEPTH];
  logic [4:0]            r_rs2   [DEPTH];
  logic [4:0]            r_rd    [DEPTH];

  // Control state
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_cmt;
  logic [DEPTH-1:0] r_kill;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [NREGS-1:0] r_pend;

  logic             w_hd_valid;
  logic             w_conflict;
  logic             w_disp_valid;
  logic             w_pop_kill;
  logic             w_pop;
  logic             w_full;
  logic             w_id_hit;
  logic             w_issue;
  logic             w_issue_cmt;
  logic [NREGS-1:0] w_pend_nxt;

  assign w_hd_valid   = r_valid[r_head];
  assign w_conflict   = |(r_pend & f_use(r_instr[r_head], r_rs1[r_head],
                                         r_rs2[r_head], r_rd[r_head]));
  assign w_disp_valid = w_hd_valid && r_cmt[r_head] && !r_kill[r_head] && !w_conflict;
  // A killed head leaves regardless of hazards; it never reaches EX.
  assign w_pop_kill   = w_hd_valid && r_cmt[r_head] && r_kill[r_head];
  assign w_pop        = (w_disp_valid && dispatch_ready_i) || w_pop_kill;

  always_comb begin
    w_id_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_id[i] == issue_id_i)) w_id_hit = 1'b1;
    end
  end

  // Ready looks at pre-pop state only, so it never depends on dispatch_ready_i.
  assign w_full        = (r_count == CW'(DEPTH));
  assign issue_ready_o = !w_full && (issue_instr_i != INSTR_INVALID) && !w_id_hit;
  assign w_issue       = issue_valid_i && issue_ready_o;
  // Commit for the very ID being issued this cycle lands on the new entry.
  assign w_issue_cmt   = commit_valid_i && (commit_id_i == issue_id_i);

  // Dispatch setting a bit wins over a same-cycle WB clear of that bit.
  always_comb begin
    w_pend_nxt = r_pend;
    if (wb_valid_i) w_pend_nxt = w_pend_nxt & ~f_bit(wb_rd_i);
    if (w_disp_valid && dispatch_ready_i && f_writes(r_instr[r_head]))
      w_pend_nxt = w_pend_nxt | f_bit(r_rd[r_head]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_cmt   <= '0;
      r_kill  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pend  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_valid_i && r_valid[i] && (r_id[i] == commit_id_i)) begin
          r_cmt[i] <= 1'b1;
          if (commit_kill_i) r_kill[i] <= 1'b1;
        end
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      // Tail slot is invalid when issuing, so it never collides with the loop above.
      if (w_issue) begin
        r_valid[r_tail] <= 1'b1;
        r_cmt[r_tail]   <= w_issue_cmt;
        r_kill[r_tail]  <= w_issue_cmt && commit_kill_i;
        r_tail          <= r_tail + PW'(1);
      end
      case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_issue) begin
      r_instr[r_tail] <= issue_instr_i;
      r_id[r_tail]    <= issue_id_i;
      r_rs1[r_tail]   <= issue_rs1_i;
      r_rs2[r_tail]   <= issue_rs2_i;
      r_rd[r_tail]    <= issue_rd_i;
    end
  end

  assign dispatch_valid_o = w_disp_valid;
  assign dispatch_instr_o = w_hd_valid ? r_instr[r_head] : '0;
  assign dispatch_id_o    = w_hd_valid ? r_id[r_head]    : '0;
  assign dispatch_rs1_o   = w_hd_valid ? r_rs1[r_head]   : '0;
  assign dispatch_rs2_o   = w_hd_valid ? r_rs2[r_head]   : '0;
  assign dispatch_rd_o    = w_hd_valid ? r_rd[r_head]    : '0;
  assign busy_o           = (|r_valid) || (|r_pend);

endmodule

// File: doc/fir_xifu_ctrl.md
# fir_xifu_ctrl

In-order issue/commit scoreboard and dispatch controller for the FIR XIF unit. It sits between the XIF issue/commit interface and the ID→EX pipeline. It buffers accepted offloaded instructions (xfirlw, xfirsw, xfirdotp) until the core commits or kills them. Committed instructions are released to EX in program order, and an instruction is held back while any internal FIR register it touches still has a write outstanding in EX/WB.

## Interface
- X_ID_WIDTH, 4, width of XIF instruction ID
- DEPTH, 4, in-flight entry count (power of 2, ≥2)
- NREGS, 32, internal FIR register count (index width 5)
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  decoded offload request valid
- issue_ready_o  out  1  request accepted when high with issue_valid_i
- issue_instr_i  in  2  fir_xifu_instr_t encoding
- issue_id_i  in  X_ID_WIDTH  XIF ID
- issue_rs1_i / issue_rs2_i / issue_rd_i  in  5 each  internal register indices
- commit_valid_i  in  1  commit/kill strobe
- commit_id_i  in  X_ID_WIDTH  ID being committed or killed
- commit_kill_i  in  1  1 = kill, 0 = commit
- dispatch_valid_o  out  1  head entry released to EX
- dispatch_ready_i  in  1  EX accepts dispatch
- dispatch_instr_o  out  2, dispatch_id_o  out  X_ID_WIDTH, dispatch_rs1_o / dispatch_rs2_o / dispatch_rd_o  out  5 each  head entry fields
- wb_valid_i  in  1  WB stage writes the internal register file
- wb_rd_i  in  5  register written by WB
- busy_o  out  1  any entry valid or any pending-write bit set

## Operation
- Storage: circular FIFO of DEPTH entries with head/tail pointers and a count. Each entry holds {instr, id, rs1, rs2, rd, committed, killed}. Pending-write bitmask pend[NREGS].
- Register usage per instruction:
  - XFIRLW writes rd and reads nothing.
  - XFIRSW reads rs2 and writes nothing.
  - XFIRDOTP reads rs1, rs2 and rd, and writes rd.
  - INSTR_INVALID is never accepted: issue_ready_o stays 0 for it.
- Issue:
  - issue_ready_o = !full && instr≠INVALID && no valid entry holds issue_id_i.
  - On handshake, the entry is written at tail with committed=killed=0, and tail advances modulo DEPTH.
- Commit/kill:
  - On commit_valid_i, every valid entry whose id equals commit_id_i gets committed=1, plus killed=1 if commit_kill_i.
  - If an issue handshake in the same cycle carries the same ID, the new entry is written already committed (and killed if commit_kill_i).
  - A commit to an unknown ID is ignored.
- Head hazard: a valid head entry conflicts if pend is set for any register it reads or writes. pend is the registered value only; a same-cycle WB clear does not unblock.
- Dispatch:
  - dispatch_valid_o = head valid && committed && !killed && !conflict.
  - On dispatch_valid_o && dispatch_ready_i: the head pops. If the instruction writes rd, pend[rd] is set.
- Killed head: popped in one cycle with dispatch_valid_o=0. It never sets pend.
- Writeback: wb_valid_i clears pend[wb_rd_i]. If a dispatch sets the same bit in the same cycle, the set wins.
- A simultaneous issue and pop both take effect. The count is unchanged and a full FIFO stays full, so issue_ready_o is evaluated on the pre-pop state and stays 0.
- Head entry not yet committed: the head stalls. There is no out-of-order release.

## Timing
- Reset (async assert, sync-safe deassert): all entries invalid, pointers 0, count 0, pend 0. Outputs during and after reset:
  - issue_ready_o = 1 for a valid instr.
  - dispatch_valid_o = 0.
  - busy_o = 0.
  - Dispatch fields = 0.
- Reset mid-operation discards all entries and pending bits without dispatching.
- Issue→dispatch latency: 1 cycle minimum, when committed by or in the issue cycle, FIFO empty and no conflict.
- Commit→dispatch: 1 cycle after the commit strobe for an entry at head.
- WB→unblock: dispatch_valid_o rises the cycle after wb_valid_i clears the conflicting bit.
- dispatch_* outputs are stable while dispatch_valid_o=1 and dispatch_ready_i=0.
- issue_ready_o and dispatch_valid_o are combinational from registered state plus the issue inputs only. There is no path from dispatch_ready_i to issue_ready_o.
- Throughput: 1 dispatch per cycle when there are no hazards.

## Test plan
- Back-to-back, independent instructions:
  - Stimulus: XFIRLW id=1 rd=3 with commit in the same cycle, then XFIRLW id=2 rd=4 committed.
  - Required: dispatch_valid_o in cycles 1 and 2, in order. pend[3] and pend[4] are set. busy_o stays 1 until WB clears both.
- RAW hazard:
  - Stimulus: XFIRLW rd=5 dispatched, then XFIRDOTP rs1=5 rs2=6 rd=7 committed.
  - Required: dispatch held until wb_valid_i with wb_rd_i=5, then dispatch_valid_o=1 the next cycle.
- Kill:
  - Stimulus: issue id=3 and id=4, kill id=3, commit id=4.
  - Required: id=3 is popped silently with no dispatch_valid_o. id=4 dispatches one cycle later. pend is unaffected by id=3.
- Full and ID collision:
  - Stimulus: issue 4 uncommitted IDs 0–3.
  - Required: issue_ready_o=0 for a 5th request. It is also 0 for a re-issue of id=2 while id=2 is valid. Committing id=0 pops it, and issue_ready_o returns to 1 on the next cycle.
- Same-cycle set and clear:
  - Stimulus: dispatch XFIRLW rd=9 in the same cycle as wb_valid_i with wb_rd_i=9.
  - Required: pend[9]=1 afterwards.
- Reset mid-flight:
  - Stimulus: assert rst_ni=0 with 3 entries valid and pend[2]=1.
  - Required: immediately busy_o=0, dispatch_valid_o=0 and issue_ready_o=1. No dispatch after release.
